spike_event_arbiter: RTL and testbench
======================================

SPIKE_EVENT_ARBITER -- requirements
Module: spike_event_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event queue depth; power of two, minimum 2.
REQ-002 SHALL have parameter TS_W, default 16, line-timestamp width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port line_sync  input  1  end-of-line strobe, one cycle.
REQ-006 SHALL have ports spike_drift, spike_spread, spike_shock  input  1 each  single-cycle spike pulses from the encoder.
REQ-007 SHALL have port ev_valid  output  1  queue head holds an event.
REQ-008 SHALL have port ev_ready  input  1  SNN consumer accepts the head event.
REQ-009 SHALL have port ev_addr  output  2  source channel: 0 drift, 1 spread, 2 shock; 3 never emitted.
REQ-010 SHALL have port ev_ts  output  TS_W  line timestamp captured when the spike arrived.
REQ-011 SHALL have port drop_count  output  8  coalesced-spike counter, saturating.
REQ-012 SHALL have port busy  output  1  high when any channel is pending or ev_valid is high.

Function
REQ-013 SHALL increment line counter ts_cnt by 1 on each line_sync, wrapping from 2^TS_W-1 to 0.
REQ-014 SHALL, per channel, set pending[c] and capture pend_ts[c]=ts_cnt on a spike pulse when pending[c] is clear; a line_sync in the same cycle does not affect the captured value (pre-increment value).
REQ-015 SHALL, on a spike pulse while pending[c] is already set and not granted that cycle, keep the original pend_ts[c] and increment drop_count by 1, saturating at 255.
REQ-016 SHALL, on a spike pulse on the same cycle channel c is granted, keep pending[c] set with pend_ts[c] reloaded; no drop counted.
REQ-017 SHALL count multiple simultaneous coalesced drops as one increment per cycle per dropped channel (up to +3 per cycle), still saturating at 255.
REQ-018 SHALL grant at most one pending channel per cycle, only when the queue is not full (occupancy evaluated before this cycle's pop).
REQ-019 SHALL arbitrate round-robin: search starts at channel (last_grant+1) mod 3; last_grant updates only on a grant.
REQ-020 SHALL, on a grant, clear pending[c] and push {c, pend_ts[c]} into the queue in the same edge.
REQ-021 SHALL present the queue head on ev_addr/ev_ts with ev_valid = queue not empty; pop on ev_valid && ev_ready.
REQ-022 SHALL hold ev_addr/ev_ts stable while ev_valid && !ev_ready.
REQ-023 SHALL allow push and pop in the same cycle at any non-full occupancy; occupancy unchanged.
REQ-024 SHALL give latency spike-to-ev_valid of 2 cycles with empty queue and no contention: spike sampled at edge N sets pending, grant/push at edge N+1, ev_valid high after edge N+1.
REQ-025 SHALL drive ev_addr=0 and ev_ts=0 when ev_valid is low.

Reset
REQ-026 SHALL, on rst high at a clock edge, clear pending[2:0], pend_ts, ts_cnt, drop_count, queue pointers and occupancy; ev_valid=0, busy=0, last_grant=2 (drift searched first).
REQ-027 SHALL discard all queued and pending events on reset asserted mid-operation; spikes sampled while rst is high are ignored.

Configuration
REQ-028 SHALL support macro SPIKE_SHOCK_PRIORITY_EN: when defined, a pending shock channel always wins, and round-robin applies between drift and spread only; shock grants do not update last_grant.
REQ-029 SHALL, without SPIKE_SHOCK_PRIORITY_EN, apply plain three-way round-robin per REQ-019.

Verification
REQ-030 SHALL verify: reset, ev_ready=1, single spike_drift at ts_cnt=5 -> ev_valid 2 cycles later, ev_addr=0, ev_ts=5, busy low the cycle after pop.
REQ-031 SHALL verify: all three spikes same cycle from reset, ev_ready=1, macro undefined -> ev_addr order 0,1,2 on consecutive cycles; macro defined -> 2,0,1.
REQ-032 SHALL verify: ev_ready=0, 5 non-coalescing spikes over distinct channels/cycles, FIFO_DEPTH=4 -> 4 queued, 5th stays pending, released one cycle after first pop; no drop counted.
REQ-033 SHALL verify: ev_ready=0, queue full, spike_spread pulsed 300 times -> drop_count saturates at 255, ev_ts of spread event equals ts of first pulse.
REQ-034 SHALL verify: ts_cnt at 2^TS_W-1, line_sync plus spike_shock same cycle -> ev_ts=2^TS_W-1, next captured ts=0.
REQ-035 SHALL verify: rst pulsed with 3 queued and 2 pending -> next cycle ev_valid=0, busy=0, drop_count=0, no stale events emitted afterwards.

Source files
------------

// File: rtl/spike_event_arbiter_if.sv
// Event stream from the spike arbiter to the SNN consumer.
// The master drives the head event and the slave returns ev_ready.
interface spike_event_arbiter_if #(
   parameter int TS_W = 16
) ();
   logic            ev_valid;
   logic            ev_ready;
   logic [1:0]      ev_addr;
   logic [TS_W-1:0] ev_ts;

   modport master (output ev_valid, output ev_addr, output ev_ts, input ev_ready);
   modport slave  (input ev_valid, input ev_addr, input ev_ts, output ev_ready);
endinterface

// File: rtl/spike_event_arbiter.sv
// Coalesces 3 spike channels into a timestamped event queue (spike to ev_valid in 2 cycles, ev_ready backpressure holds the head).
// Round-robin grant by default; with SPIKE_SHOCK_PRIORITY_EN defined, a pending shock always wins.
module spike_event_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int TS_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 line_sync,
   input  logic                 spike_drift,
   input  logic                 spike_spread,
   input  logic                 spike_shock,
   spike_event_arbiter_if.master ev,
   output logic [7:0]           drop_count,
   output logic                 busy
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [1:0]      addr;
      logic [TS_W-1:0] ts;
   } ev_t;

   ev_t             mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     occ;
   logic [TS_W-1:0] ts_cnt;
   logic [2:0]      pending;
   logic [TS_W-1:0] pend_ts [3];
   logic [1:0]      last_grant;

   logic [2:0]      spike;
   logic            full, pop;
   logic            gnt_vld;
   logic [1:0]      gnt_ch;
   logic [2:0]      gnt_oh;
   logic [2:0]      drop;
   logic [1:0]      drop_inc;
   logic [8:0]      drop_sum;
   logic [7:0]      drop_next;
   ev_t             head;

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   assign spike = {spike_shock, spike_spread, spike_drift};
   assign full  = (occ == (AW+1)'(FIFO_DEPTH));
   assign pop   = ev.ev_valid && ev.ev_ready;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = 2'd0;
      if (!full) begin
`ifdef SPIKE_SHOCK_PRIORITY_EN
         // Shock bypasses the rotation; drift/spread alternate via last_grant.
         if (pending[2]) begin
            gnt_vld = 1'b1;
            gnt_ch  = 2'd2;
         end else if (pending[0] && pending[1]) begin
            gnt_vld = 1'b1;
            gnt_ch  = (last_grant == 2'd0) ? 2'd1 : 2'd0;
         end else if (pending[0] || pending[1]) begin
            gnt_vld = 1'b1;
            gnt_ch  = pending[0] ? 2'd0 : 2'd1;
         end
`else
         // Scan from the farthest offset down so the nearest pending channel wins.
         for (int i = 2; i >= 0; i--) begin
            if (pending[wrap3({1'b0, wrap3({1'b0, last_grant} + 3'd1)} + 3'(i))]) begin
               gnt_vld = 1'b1;
               gnt_ch  = wrap3({1'b0, wrap3({1'b0, last_grant} + 3'd1)} + 3'(i));
            end
         end
`endif
      end
   end

   assign gnt_oh    = gnt_vld ? (3'b001 << gnt_ch) : 3'b000;
   assign drop      = spike & pending & ~gnt_oh;
   assign drop_inc  = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
   assign drop_sum  = {1'b0, drop_count} + {7'd0, drop_inc};
   assign drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt     <= '0;
         pending    <= 3'b000;
         drop_count <= 8'd0;
         last_grant <= 2'd2;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         for (int c = 0; c < 3; c++) pend_ts[c] <= '0;
      end else begin
         if (line_sync) ts_cnt <= ts_cnt + 1'b1;
         // A spike landing on its own grant cycle starts a fresh pending event.
         for (int c = 0; c < 3; c++) begin
            if (spike[c] && (!pending[c] || gnt_oh[c])) begin
               pending[c] <= 1'b1;
               pend_ts[c] <= ts_cnt;
            end else if (gnt_oh[c]) begin
               pending[c] <= 1'b0;
            end
         end
         drop_count <= drop_next;
         if (gnt_vld) begin
            wr_ptr <= wr_ptr + 1'b1;
`ifdef SPIKE_SHOCK_PRIORITY_EN
            if (gnt_ch != 2'd2) last_grant <= gnt_ch;
`else
            last_grant <= gnt_ch;
`endif
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({gnt_vld, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && gnt_vld) mem[wr_ptr] <= '{addr: gnt_ch, ts: pend_ts[gnt_ch]};
   end

   assign head        = mem[rd_ptr];
   assign ev.ev_valid = (occ != '0);
   assign ev.ev_addr  = ev.ev_valid ? head.addr : 2'd0;
   assign ev.ev_ts    = ev.ev_valid ? head.ts : '0;
   assign busy        = (|pending) || ev.ev_valid;
endmodule

// File: tb/tb_spike_event_arbiter.sv
// Directed self-checking bench for spike_event_arbiter (TS_W=8, FIFO_DEPTH=4).
module tb_spike_event_arbiter;
   localparam int TS_W = 8;
   localparam logic [TS_W-1:0] TS_MAX = '1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_sync = 1'b0;
   logic       spike_drift = 1'b0, spike_spread = 1'b0, spike_shock = 1'b0;
   logic [7:0] drop_count;
   logic       busy;
   int         n_cmp = 0;
   int         n_err = 0;

   spike_event_arbiter_if #(.TS_W(TS_W)) ev_if ();

   spike_event_arbiter #(.FIFO_DEPTH(4), .TS_W(TS_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .line_sync    (line_sync),
      .spike_drift  (spike_drift),
      .spike_spread (spike_spread),
      .spike_shock  (spike_shock),
      .ev           (ev_if.master),
      .drop_count   (drop_count),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_spike(input int c, input logic v);
      case (c)
         0:       spike_drift  = v;
         1:       spike_spread = v;
         default: spike_shock  = v;
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b1;
      line_sync = 1'b0;
      spike_drift = 1'b0; spike_spread = 1'b0; spike_shock = 1'b0;
      ev_if.ev_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (ev_if.ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ev_if.ev_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
      n_cmp++; if (ev_if.ev_addr !== 2'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", ev_if.ev_addr); end
      n_cmp++; if (ev_if.ev_ts !== 8'd0) begin n_err++; $display("FAIL reset_ts: got %0d want 0", ev_if.ev_ts); end
   endtask

   task automatic test_single();
      do_reset();
      ev_if.ev_ready = 1'b1;
      repeat (5) begin
         line_sync = 1'b1; tick();
         line_sync = 1'b0; tick();
      end
      spike_drift = 1'b1; tick(); spike_drift = 1'b0;
      n_cmp++; if (ev_if.ev_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", ev_if.ev_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_pending_busy: got %b want 1", busy); end
      tick();
      n_cmp++; if (ev_if.ev_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", ev_if.ev_valid); end
      n_cmp++; if (ev_if.ev_addr !== 2'd0) begin n_err++; $display("FAIL single_addr: got %0d want 0", ev_if.ev_addr); end
      n_cmp++; if (ev_if.ev_ts !== 8'd5) begin n_err++; $display("FAIL single_ts: got %0d want 5", ev_if.ev_ts); end
      tick();
      n_cmp++; if (ev_if.ev_valid !== 1'b0) begin n_err++; $display("FAIL single_popped: got %b want 0", ev_if.ev_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_simultaneous();
      logic [1:0] exp_order [3];
`ifdef SPIKE_SHOCK_PRIORITY_EN
      exp_order = '{2'd2, 2'd0, 2'd1};
`else
      exp_order = '{2'd0, 2'd1, 2'd2};
`endif
      do_reset();
      ev_if.ev_ready = 1'b1;
      spike_drift = 1'b1; spike_spread = 1'b1; spike_shock = 1'b1;
      tick();
      spike_drift = 1'b0; spike_spread = 1'b0; spike_shock = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== exp_order[i]) begin
            n_err++; $display("FAIL simul_order[%0d]: got valid=%b addr=%0d want valid=1 addr=%0d", i, ev_if.ev_valid, ev_if.ev_addr, exp_order[i]);
         end
      end
      tick();
      n_cmp++; if (ev_if.ev_valid !== 1'b0) begin n_err++; $display("FAIL simul_drained: got %b want 0", ev_if.ev_valid); end
   endtask

   task automatic test_backpressure();
      int         seq [5] = '{0, 1, 2, 0, 1};
      logic [1:0] drain [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_spike(seq[i], 1'b1); tick(); set_spike(seq[i], 1'b0);
      end
      tick();
      tick();
      n_cmp++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 2'd0) begin
         n_err++; $display("FAIL bp_head: got valid=%b addr=%0d want valid=1 addr=0", ev_if.ev_valid, ev_if.ev_addr);
      end
      n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL bp_drop: got %0d want 0", drop_count); end
      ev_if.ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== drain[i]) begin
            n_err++; $display("FAIL bp_drain[%0d]: got valid=%b addr=%0d want valid=1 addr=%0d", i, ev_if.ev_valid, ev_if.ev_addr, drain[i]);
         end
      end
      tick();
      n_cmp++; if (ev_if.ev_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL bp_empty: got valid=%b busy=%b want 0 0", ev_if.ev_valid, busy);
      end
   endtask

   task automatic test_saturate();
      int         fill [4] = '{0, 2, 0, 2};
      logic [1:0] drain [4] = '{2'd2, 2'd0, 2'd2, 2'd1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_spike(fill[i], 1'b1); tick(); set_spike(fill[i], 1'b0);
      end
      tick();
      line_sync = 1'b1; tick();
      spike_spread = 1'b1;
      repeat (300) tick();
      spike_spread = 1'b0; line_sync = 1'b0;
      n_cmp++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL sat_drop: got %0d want 255", drop_count); end
      n_cmp++; if (ev_if.ev_addr !== 2'd0) begin n_err++; $display("FAIL sat_head: got %0d want 0", ev_if.ev_addr); end
      ev_if.ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== drain[i]) begin
            n_err++; $display("FAIL sat_drain[%0d]: got valid=%b addr=%0d want valid=1 addr=%0d", i, ev_if.ev_valid, ev_if.ev_addr, drain[i]);
         end
      end
      n_cmp++; if (ev_if.ev_ts !== 8'd1) begin n_err++; $display("FAIL sat_spread_ts: got %0d want 1", ev_if.ev_ts); end
      tick();
      n_cmp++; if (ev_if.ev_valid !== 1'b0) begin n_err++; $display("FAIL sat_empty: got %b want 0", ev_if.ev_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      ev_if.ev_ready = 1'b1;
      line_sync = 1'b1;
      repeat (255) tick();
      spike_shock = 1'b1; tick();
      line_sync = 1'b0; tick();
      spike_shock = 1'b0;
      n_cmp++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 2'd2) begin
         n_err++; $display("FAIL wrap_head: got valid=%b addr=%0d want valid=1 addr=2", ev_if.ev_valid, ev_if.ev_addr);
      end
      n_cmp++; if (ev_if.ev_ts !== TS_MAX) begin n_err++; $display("FAIL wrap_ts_max: got %0d want %0d", ev_if.ev_ts, TS_MAX); end
      tick();
      n_cmp++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_ts !== 8'd0) begin
         n_err++; $display("FAIL wrap_ts_zero: got valid=%b ts=%0d want valid=1 ts=0", ev_if.ev_valid, ev_if.ev_ts);
      end
      n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL wrap_drop: got %0d want 0", drop_count); end
      tick();
      n_cmp++; if (ev_if.ev_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %b want 0", ev_if.ev_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      spike_drift = 1'b1; spike_spread = 1'b1; spike_shock = 1'b1; tick();
      spike_drift = 1'b0; spike_shock = 1'b0; tick();
      spike_spread = 1'b0;
      tick();
      tick();
      spike_drift = 1'b1; spike_spread = 1'b1; tick();
      n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL mid_drop_before: got %0d want 1", drop_count); end
      n_cmp++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 2'd0) begin
         n_err++; $display("FAIL mid_head_before: got valid=%b addr=%0d want valid=1 addr=0", ev_if.ev_valid, ev_if.ev_addr);
      end
      rst = 1'b1; spike_shock = 1'b1; tick();
      rst = 1'b0; spike_drift = 1'b0; spike_spread = 1'b0; spike_shock = 1'b0;
      n_cmp++; if (ev_if.ev_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", ev_if.ev_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL mid_drop: got %0d want 0", drop_count); end
      ev_if.ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (ev_if.ev_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL mid_stale[%0d]: got valid=%b busy=%b want 0 0", i, ev_if.ev_valid, busy);
         end
      end
   endtask

   initial begin
      ev_if.ev_ready = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_saturate();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
